// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit buffer.
package uart_pkg;

    localparam int PAYLOAD_BITS_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SENT = 2'd1,
        S_WAIT = 2'd2
    } rd_state_t;

    // Count needs one extra bit so that "DEPTH entries" is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module sync_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter through its enable/busy handshake.
// Optional level/threshold outputs are built when UART_TX_FIFO_LEVEL_EN is defined.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [PAYLOAD_BITS-1:0]        wr_data,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic                           tx_en,
    output logic [PAYLOAD_BITS-1:0]        tx_data,
`ifdef UART_TX_FIFO_LEVEL_EN
    output logic [count_width(DEPTH)-1:0]  level,
    output logic                           threshold_irq,
`endif
    input  logic                           tx_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    // Handshake: a byte is handed over by a single-cycle tx_en with tx_data
    // valid alongside; the next byte waits until tx_busy has been seen low.
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_overflow;
    logic                    r_tx_en;
    logic [PAYLOAD_BITS-1:0] r_tx_data;
    rd_state_t               r_state;

    rd_state_t               w_state_next;
    logic                    w_push;
    logic                    w_pop;
    logic [CW-1:0]           w_count_next;
    logic [PAYLOAD_BITS-1:0] w_rd_data;
    logic                    w_full;
    logic                    w_empty;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SENT;
                end
            end
            // Transmitter raises busy one cycle after sampling tx_en.
            S_SENT:  w_state_next = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_overflow <= wr_en && w_full;
            r_tx_en    <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PW'(1);
                r_tx_data <= w_rd_data;
            end
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    logic r_threshold_irq;

    // Registered from the next count so it lines up with level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_threshold_irq <= 1'b0;
        end else begin
            r_threshold_irq <= (w_count_next <= CW'(DEPTH / 4));
        end
    end

    assign level         = r_count;
    assign threshold_irq = r_threshold_irq;
`endif

    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign tx_en    = r_tx_en;
    assign tx_data  = r_tx_data;

endmodule
